prbs_checker: RTL

Downstream consumer of the 5-bit PRBS LED generator. It takes the generator's newest output bit, one bit per PRBS step, and self-synchronises a local copy of the same LFSR (x^5 + x^4 + 1, taps 4 and 3). Once locked, it flags and counts every bit that disagrees with the local reference. It sits between the PRBS source (or a loop-back of its LED pins) and a status/debug display.

---
 rtl/prbs_checker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// Receives the newest output bit of a 5-bit PRBS generator (x^5 + x^4 + 1),
// one bit per PRBS step. It self-synchronises a local copy of the LFSR and,
// once locked, flags and counts every received bit that disagrees with the
// local reference.
//
// The checker moves through three states:
//   SEED   - loads SIZE received bits into the history register.
//   SYNC   - checks that received bits follow the LFSR recurrence.
//   LOCKED - the reference free-runs, and mismatches are counted as errors.
//
// Ports:
//   CLOCK_12   in   12 MHz system clock, the only clock
//   RST        in   asynchronous active-low reset
//   DIN_VALID  in   single-cycle strobe, one per PRBS step
//   DIN        in   received bit, sampled only when DIN_VALID=1
//   CLR_ERR    in   synchronous clear of ERR_COUNT
//   LOCKED     out  high while in the LOCKED state (registered)
//   ERR        out  one-cycle pulse per mismatching bit while locked
//   ERR_COUNT  out  saturating count of errors seen while locked
// -----------------------------------------------------------------------------
module prbs_checker #(
    parameter int SIZE        = 5,
    parameter int TAP1        = 4,
    parameter int TAP2        = 3,
    parameter int LOCK_COUNT  = 8,
    parameter int LOSS_ERRORS = 3,
    parameter int ERR_W       = 8
) (
    input  logic             CLOCK_12,
    input  logic             RST,
    input  logic             DIN_VALID,
    input  logic             DIN,
    input  logic             CLR_ERR,
    output logic             LOCKED,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_COUNT
);

    localparam int SEED_W = $clog2(SIZE + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(LOSS_ERRORS + 1);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_SYNC,
        ST_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   hist_q, hist_d;
    logic [SEED_W-1:0] seed_cnt_q, seed_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              locked_q;
    logic              err_q;

    logic              pred;
    logic              err_event;

    assign pred = hist_q[TAP1] ^ hist_q[TAP2];

    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        seed_cnt_d = seed_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_event  = 1'b0;

        if (DIN_VALID) begin
            unique case (state_q)
                ST_SEED: begin
                    hist_d     = {hist_q[SIZE-2:0], DIN};
                    seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    if (seed_cnt_q == SEED_W'(SIZE - 1)) begin
                        state_d    = ST_SYNC;
                        good_cnt_d = '0;
                    end
                end

                ST_SYNC: begin
                    // All-zero history is the LFSR lock-up state: zeros
                    // "predict" zeros forever, so this never counts as a match.
                    if ((DIN == pred) && (hist_q != '0)) begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                    end else begin
                        good_cnt_d = '0;
                    end
                    hist_d = {hist_q[SIZE-2:0], DIN};
                    if (good_cnt_d == GOOD_W'(LOCK_COUNT)) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end
                end

                ST_LOCKED: begin
                    if (DIN != pred) begin
                        err_event  = 1'b1;
                        bad_cnt_d  = bad_cnt_q + BAD_W'(1);
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                        // A full run of clean bits forgives earlier errors.
                        if (good_cnt_d == GOOD_W'(LOCK_COUNT)) begin
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end
                    end
                    // The reference free-runs on its own prediction, so one
                    // corrupted bit costs exactly one error.
                    hist_d = {hist_q[SIZE-2:0], pred};
                    if (bad_cnt_d == BAD_W'(LOSS_ERRORS)) begin
                        state_d    = ST_SEED;
                        seed_cnt_d = '0;
                        hist_d     = '0;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end
                end

                default: state_d = ST_SEED;
            endcase
        end
    end

    // A clear that coincides with a counted error leaves that error counted.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (CLR_ERR) begin
            err_cnt_d = ERR_W'(err_event);
        end else if (err_event && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge inputs no matter what order the statements are in.
    always_ff @(posedge CLOCK_12 or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_SEED;
            hist_q     <= '0;
            seed_cnt_q <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            err_cnt_q  <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            seed_cnt_q <= seed_cnt_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            err_cnt_q  <= err_cnt_d;
            locked_q   <= (state_d == ST_LOCKED);
            err_q      <= err_event;
        end
    end

    assign LOCKED    = locked_q;
    assign ERR       = err_q;
    assign ERR_COUNT = err_cnt_q;

endmodule
